// File: rtl/obi_pkg.sv
// Shared OBI bus package: request/response payloads and the memory
// responder's width constants and wait-state FSM encoding.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = 4;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } obi_mem_wait_state_e;

endpackage

// File: rtl/obi_mem_bank.sv
// Single-port word storage with per-byte write enables and a registered
// read port. Kept separate so a technology SRAM wrapper can drop in.
module obi_mem_bank
    import obi_pkg::*;
#(
    parameter int unsigned NumWords = 1024,
    parameter int unsigned AddrW    = $clog2(NumWords)
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [OBI_BE_W-1:0]   be_i,
    input  logic [AddrW-1:0]      addr_i,
    input  logic [OBI_DATA_W-1:0] wdata_i,
    output logic [OBI_DATA_W-1:0] rdata_o
);

    logic [OBI_DATA_W-1:0] mem_q [NumWords];

    // Byte-masked write, or registered read of the addressed word
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < int'(OBI_BE_W); k++) begin
                    if (be_i[k]) begin
                        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/obi_mem_responder.sv
// OBI responder terminating one port with an internal byte-writable memory.
// Optional wait states before gnt are enabled with the macro OBI_MEM_WAIT_EN;
// without it gnt follows req directly and WaitCycles has no effect.
module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned WaitCycles = 0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  req_i,
    output obi_resp_t resp_o
);

    localparam int unsigned AddrW = $clog2(NumWords);

    logic                  gnt_c;
    logic                  accept_c;
    logic                  rvalid_q;
    logic                  we_q;
    logic [AddrW-1:0]      word_idx_c;
    logic [OBI_DATA_W-1:0] bank_rdata;
    logic                  unused_c;

    // Word index; byte offset and bits above the memory size alias away
    assign word_idx_c = req_i.addr[AddrW+1:2];
    assign unused_c   = ^{req_i.addr[OBI_ADDR_W-1:AddrW+2], req_i.addr[1:0], 4'(WaitCycles)};

`ifdef OBI_MEM_WAIT_EN
    localparam logic [3:0] WaitN = 4'(WaitCycles);

    obi_mem_wait_state_e state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    // Wait-state FSM register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count wait cycles while req is held; grant once the count reaches WaitN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_c   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (req_i.req) begin
                        if (WaitN == 4'd0) begin
                            gnt_c = 1'b1;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req_i.req) begin
                        // Initiator withdrew req: abandon the wait, no access
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else if (cnt_q == WaitN) begin
                        gnt_c   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end
`else
    // Zero-wait grant, held low during reset
    assign gnt_c = req_i.req & ~rst_i;
`endif

    assign accept_c = req_i.req & gnt_c;

    obi_mem_bank #(
        .NumWords (NumWords),
        .AddrW    (AddrW)
    ) u_bank (
        .clk_i   (clk_i),
        .en_i    (accept_c),
        .we_i    (req_i.we),
        .be_i    (req_i.be),
        .addr_i  (word_idx_c),
        .wdata_i (req_i.wdata),
        .rdata_o (bank_rdata)
    );

    // Response valid one cycle after accept; remember whether it was a write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            rvalid_q <= accept_c;
            if (accept_c) begin
                we_q <= req_i.we;
            end
        end
    end

    // Reset in the response cycle suppresses it; writes return zero data
    assign resp_o.gnt    = gnt_c;
    assign resp_o.rvalid = rvalid_q & ~rst_i;
    assign resp_o.rdata  = (rvalid_q & ~we_q & ~rst_i) ? bank_rdata : '0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level model (word array + grant latency).
module tb_obi_mem_responder;
    import obi_pkg::*;

    localparam int unsigned NumWords   = 1024;
    localparam int unsigned WaitCycles = 3;
    localparam int unsigned AW         = $clog2(NumWords);
`ifdef OBI_MEM_WAIT_EN
    localparam int unsigned Lat = WaitCycles;
`else
    localparam int unsigned Lat = 0;
`endif

    logic      clk = 1'b0;
    logic      rst_i;
    obi_req_t  req_i;
    obi_resp_t resp_o;

    always #5 clk = ~clk;

    obi_mem_responder #(
        .NumWords   (NumWords),
        .WaitCycles (WaitCycles)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .resp_o (resp_o)
    );

    // Reference model state
    logic [31:0] mem_m [NumWords];
    bit          pend_valid;
    logic [31:0] pend_data;
    int unsigned wait_cnt;
    bit          last_gnt;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model
    task automatic step(input bit rst, input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bit             exp_gnt;
        bit             exp_rv;
        logic [AW-1:0]  idx;
        @(negedge clk);
        rst_i       = rst;
        req_i.req   = req;
        req_i.we    = we;
        req_i.be    = be;
        req_i.addr  = addr;
        req_i.wdata = wdata;
        #1;
        exp_gnt = !rst && req && (wait_cnt == Lat);
        exp_rv  = pend_valid && !rst;
        check("gnt", 32'(resp_o.gnt), 32'(exp_gnt));
        check("rvalid", 32'(resp_o.rvalid), 32'(exp_rv));
        if (exp_rv || rst) begin
            check("rdata", resp_o.rdata, exp_rv ? pend_data : 32'h0);
        end
        idx        = addr[AW+1:2];
        pend_valid = exp_gnt;
        pend_data  = 32'h0;
        if (exp_gnt) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem_m[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end else begin
                pend_data = mem_m[idx];
            end
        end
        wait_cnt = (rst || !req || exp_gnt) ? 0 : wait_cnt + 1;
        last_gnt = exp_gnt;
    endtask

    // Hold a request until the model says it is granted (bounded)
    task automatic xfer(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        for (int i = 0; i <= 16; i++) begin
            step(1'b0, 1'b1, we, be, addr, wdata);
            if (last_gnt) break;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        n_vec      = 0;
        n_err      = 0;
        pend_valid = 1'b0;
        pend_data  = 32'h0;
        wait_cnt   = 0;
        last_gnt   = 1'b0;
        rst_i      = 1'b1;
        req_i      = '0;

        // Reset held with req high: no grant, no response
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);

        // Write then read, then partial byte-enable write and read back
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        xfer(1'b0, 4'h0, 32'h10, 32'h0);
        xfer(1'b1, 4'h5, 32'h10, 32'h11223344);
        xfer(1'b0, 4'hF, 32'h10, 32'h0);
        xfer(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
        xfer(1'b0, 4'h0, 32'h10, 32'h0);
        idle();

        // Aliasing above the memory size
        xfer(1'b1, 4'hF, 32'h1004, 32'hA5A5A5A5);
        xfer(1'b0, 4'h0, 32'h0004, 32'h0);
        idle();

        // Four back-to-back reads of a held request
        for (int i = 0; i < 4; i++) xfer(1'b0, 4'h0, 32'h10 + 32'(i * 4), 32'h0);
        idle();

        // Reset right after a write accept: response dropped, data kept
        xfer(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        xfer(1'b0, 4'h0, 32'h40, 32'h0);
        idle();

        // Initialise the window used by random traffic
        for (int i = 0; i < 32; i++) xfer(1'b1, 4'hF, 32'(i * 4), $urandom);
        idle();

        // Random traffic: req toggling, fields changing while waiting, rare reset
        for (int i = 0; i < 600; i++) begin
            a = ($urandom & ~32'h0000_007C) | (32'($urandom_range(0, 31)) << 2);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
                 4'($urandom), a, $urandom);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
